// File: rtl/if_id_queue.sv
// if_id_queue: two-entry fetch-to-decode instruction queue with flush and optional statistics
// Ports:
//   clk                 system clock, all state updates on the rising edge
//   rst                 synchronous active-low reset
//   if_PC_in/NPC/IR     fetched instruction PC, PC+4 and instruction word
//   if_valid_inst_in    fetch slot holds a real instruction
//   d_hazard_detected   decode cannot accept the head entry this cycle
//   ex_branch_take      flush request from execute, beats push and pop
//   id_*_out            head entry (zero when empty), id_valid_inst_out = non-empty
//   ifq_full            two entries held, fetch must hold its PC
//   ifq_flush_cnt       flush cycles seen (IFQ_STATS_EN), else 0
//   ifq_stall_cnt       stalled valid head cycles (IFQ_STATS_EN), else 0
// Build option: define IFQ_STATS_EN to enable the saturating statistics counters.
module if_id_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_PC_in,
  input  logic [31:0] if_NPC_in,
  input  logic [31:0] if_IR_in,
  input  logic        if_valid_inst_in,
  input  logic        d_hazard_detected,
  input  logic        ex_branch_take,
  output logic [31:0] id_PC_out,
  output logic [31:0] id_NPC_out,
  output logic [31:0] id_IR_out,
  output logic        id_valid_inst_out,
  output logic        ifq_full,
  output logic [15:0] ifq_flush_cnt,
  output logic [15:0] ifq_stall_cnt
);
  // the state encoding doubles as the occupancy count
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  logic [1:0][31:0] pc_q, pc_d, npc_q, npc_d, ir_q, ir_d;
  logic head_q, head_d, tail_q, tail_d;
  logic push, pop;
  assign id_valid_inst_out = state_q != EMPTY;
  assign ifq_full = state_q == FULL;
  assign id_PC_out = id_valid_inst_out ? pc_q[head_q] : 32'd0;
  assign id_NPC_out = id_valid_inst_out ? npc_q[head_q] : 32'd0;
  assign id_IR_out = id_valid_inst_out ? ir_q[head_q] : 32'd0;
  assign push = if_valid_inst_in & ~ifq_full & ~ex_branch_take;
  assign pop = id_valid_inst_out & ~d_hazard_detected & ~ex_branch_take;
  always_comb begin
    pc_d = pc_q;
    npc_d = npc_q;
    ir_d = ir_q;
    head_d = pop ? ~head_q : head_q;
    tail_d = push ? ~tail_q : tail_q;
    state_d = state_q;
    if (push) begin
      pc_d[tail_q] = if_PC_in;
      npc_d[tail_q] = if_NPC_in;
      ir_d[tail_q] = if_IR_in;
    end
    case (state_q)
      EMPTY:   state_d = push ? ONE : EMPTY;
      ONE:     state_d = (push & ~pop) ? FULL : (pop & ~push) ? EMPTY : ONE;
      FULL:    state_d = pop ? ONE : FULL;
      default: state_d = EMPTY;
    endcase
    // a flush drops every entry; stale storage is masked by the empty state
    if (ex_branch_take) begin
      state_d = EMPTY;
      head_d = 1'b0;
      tail_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      pc_q <= '0;
      npc_q <= '0;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      pc_q <= pc_d;
      npc_q <= npc_d;
      ir_q <= ir_d;
    end
  end
`ifdef IFQ_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d, stall_cnt_q, stall_cnt_d;
  always_comb begin
    flush_cnt_d = (ex_branch_take && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    stall_cnt_d = (id_valid_inst_out && d_hazard_detected && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign ifq_flush_cnt = flush_cnt_q;
  assign ifq_stall_cnt = stall_cnt_q;
`else
  assign ifq_flush_cnt = 16'd0;
  assign ifq_stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed table-driven checks of the fetch-to-decode queue
module tb_if_id_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] if_PC_in = '0, if_NPC_in = '0, if_IR_in = '0;
  logic if_valid_inst_in = 1'b0, d_hazard_detected = 1'b0, ex_branch_take = 1'b0;
  logic [31:0] id_PC_out, id_NPC_out, id_IR_out;
  logic id_valid_inst_out, ifq_full;
  logic [15:0] ifq_flush_cnt, ifq_stall_cnt;
  if_id_queue dut (
    .clk(clk), .rst(rst),
    .if_PC_in(if_PC_in), .if_NPC_in(if_NPC_in), .if_IR_in(if_IR_in),
    .if_valid_inst_in(if_valid_inst_in), .d_hazard_detected(d_hazard_detected),
    .ex_branch_take(ex_branch_take),
    .id_PC_out(id_PC_out), .id_NPC_out(id_NPC_out), .id_IR_out(id_IR_out),
    .id_valid_inst_out(id_valid_inst_out), .ifq_full(ifq_full),
    .ifq_flush_cnt(ifq_flush_cnt), .ifq_stall_cnt(ifq_stall_cnt)
  );
  always #5 clk = ~clk;
`ifdef IFQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct {
    logic r, v;
    logic [31:0] pc;
    logic h, b, ev, ef;
    logic [31:0] epc;
  } vec_t;
  vec_t vecs[$];
  int passed = 0, total = 0;
  int m_flush = 0, m_stall = 0;
  logic prev_ev = 1'b0;
  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return pc == 32'd0 ? 32'h00A00093 : {16'hBEEF, pc[15:0]};
  endfunction
  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask
  task automatic add(input logic r, v, input logic [31:0] pc, input logic h, b, ev, ef, input logic [31:0] epc);
    vec_t t;
    t.r = r; t.v = v; t.pc = pc; t.h = h; t.b = b; t.ev = ev; t.ef = ef; t.epc = epc;
    vecs.push_back(t);
  endtask
  task automatic step(input vec_t t, input int idx);
    @(negedge clk);
    rst = t.r;
    if_valid_inst_in = t.v;
    if_PC_in = t.pc;
    if_NPC_in = t.pc + 32'd4;
    if_IR_in = ir_of(t.pc);
    d_hazard_detected = t.h;
    ex_branch_take = t.b;
    @(posedge clk);
    #1;
    m_flush = !t.r ? 0 : (t.b && m_flush < 65535) ? m_flush + 1 : m_flush;
    m_stall = !t.r ? 0 : (prev_ev && t.h && m_stall < 65535) ? m_stall + 1 : m_stall;
    prev_ev = t.ev;
    check("valid", idx, {31'd0, id_valid_inst_out}, {31'd0, t.ev});
    check("full", idx, {31'd0, ifq_full}, {31'd0, t.ef});
    check("pc", idx, id_PC_out, t.ev ? t.epc : 32'd0);
    check("npc", idx, id_NPC_out, t.ev ? t.epc + 32'd4 : 32'd0);
    check("ir", idx, id_IR_out, t.ev ? ir_of(t.epc) : 32'd0);
    check("flush_cnt", idx, {16'd0, ifq_flush_cnt}, STATS ? m_flush : 0);
    check("stall_cnt", idx, {16'd0, ifq_stall_cnt}, STATS ? m_stall : 0);
  endtask
  initial begin
    //  r  v  pc      h  b  ev ef epc
    add(0, 0, 32'h0,  0, 0, 0, 0, 32'h0);
    add(1, 1, 32'h0,  0, 0, 1, 0, 32'h0);
    add(1, 0, 32'h0,  0, 0, 0, 0, 32'h0);
    add(1, 1, 32'h0,  1, 0, 1, 0, 32'h0);
    add(1, 1, 32'h4,  1, 0, 1, 1, 32'h0);
    add(1, 1, 32'h8,  1, 0, 1, 1, 32'h0);
    add(1, 0, 32'h0,  0, 0, 1, 0, 32'h4);
    add(1, 0, 32'h0,  1, 0, 1, 0, 32'h4);
    add(1, 0, 32'h0,  0, 0, 0, 0, 32'h0);
    add(1, 1, 32'h10, 1, 0, 1, 0, 32'h10);
    add(1, 1, 32'h14, 1, 0, 1, 1, 32'h10);
    add(1, 1, 32'h18, 0, 0, 1, 0, 32'h14);
    add(1, 1, 32'h1C, 1, 0, 1, 1, 32'h14);
    add(1, 0, 32'h0,  0, 0, 1, 0, 32'h1C);
    add(1, 0, 32'h0,  0, 0, 0, 0, 32'h0);
    add(1, 1, 32'h20, 1, 0, 1, 0, 32'h20);
    add(1, 1, 32'h24, 1, 0, 1, 1, 32'h20);
    add(1, 1, 32'h28, 0, 1, 0, 0, 32'h0);
    add(1, 0, 32'h0,  0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) add(1, 1, 32'(4 * i), 0, 0, 1, 0, 32'(4 * i));
    add(1, 0, 32'h0,  0, 0, 0, 0, 32'h0);
    add(1, 1, 32'h40, 0, 0, 1, 0, 32'h40);
    add(0, 1, 32'h44, 0, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0,  0, 0, 0, 0, 32'h0);
    add(1, 1, 32'h48, 0, 1, 0, 0, 32'h0);
    add(1, 1, 32'h4C, 1, 0, 1, 0, 32'h4C);
    add(1, 0, 32'h0,  0, 1, 0, 0, 32'h0);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);
    vecs.delete();
    add(0, 0, 32'h0,  0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) add(1, 0, 32'h0, 0, 1, 0, 0, 32'h0);
    add(1, 1, 32'h50, 0, 0, 1, 0, 32'h50);
    for (int i = 0; i < 5; i++) add(1, 0, 32'h0, 1, 0, 1, 0, 32'h50);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], 100 + i);
    check("stats_flush3", 200, {16'd0, ifq_flush_cnt}, STATS ? 3 : 0);
    check("stats_stall5", 200, {16'd0, ifq_stall_cnt}, STATS ? 5 : 0);
    vecs.delete();
    add(0, 0, 32'h0,  1, 1, 0, 0, 32'h0);
    step(vecs[0], 201);
    check("stats_flush_rst", 202, {16'd0, ifq_flush_cnt}, 32'd0);
    check("stats_stall_rst", 202, {16'd0, ifq_stall_cnt}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL provide port clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst  input  1  reset, synchronous and active-low (state cleared on a clk rising edge while rst==0).
REQ-003 SHALL provide port if_PC_in  input  32  PC of the fetched instruction.
REQ-004 SHALL provide port if_NPC_in  input  32  PC+4 of the fetched instruction.
REQ-005 SHALL provide port if_IR_in  input  32  fetched instruction word.
REQ-006 SHALL provide port if_valid_inst_in  input  1  fetch slot holds a real instruction.
REQ-007 SHALL provide port d_hazard_detected  input  1  decode cannot accept the head entry this cycle.
REQ-008 SHALL provide port ex_branch_take  input  1  flush request from execute.
REQ-009 SHALL provide port id_PC_out  output  32  head-entry PC.
REQ-010 SHALL provide port id_NPC_out  output  32  head-entry PC+4.
REQ-011 SHALL provide port id_IR_out  output  32  head-entry instruction.
REQ-012 SHALL provide port id_valid_inst_out  output  1  head entry valid.
REQ-013 SHALL provide port ifq_full  output  1  queue full; fetch must hold its PC.
REQ-014 SHALL provide ports ifq_flush_cnt and ifq_stall_cnt  output  16 each  statistics counters (see Configuration).

Function
REQ-015 SHALL be a 2-entry FIFO with entries {PC, NPC, IR} plus head pointer, tail pointer and 2-bit count.
REQ-016 SHALL use occupancy states EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-017 push = if_valid_inst_in & ~ifq_full & ~ex_branch_take; pop = id_valid_inst_out & ~d_hazard_detected & ~ex_branch_take.
REQ-018 Transitions: EMPTY->ONE on push; ONE->FULL on push&~pop; ONE->EMPTY on pop&~push; FULL->ONE on pop; push&pop in ONE keeps ONE; otherwise hold.
REQ-019 In FULL, push SHALL be blocked, so a pop in FULL drains without refill that cycle.
REQ-020 Latency SHALL be one cycle: an instruction pushed in cycle N appears on id_* outputs in cycle N+1 when the queue was EMPTY.
REQ-021 id_* outputs SHALL reflect the head entry combinationally from registered storage; id_valid_inst_out = (count != 0).
REQ-022 When EMPTY, id_PC_out, id_NPC_out and id_IR_out SHALL be 0.
REQ-023 ifq_full SHALL equal (count == 2), driven from registered state only.
REQ-024 ex_branch_take SHALL take priority over push and pop: next cycle count=0, head=tail=0, id_valid_inst_out=0.
REQ-025 Pointers SHALL wrap modulo 2; FIFO order SHALL be preserved across wrap.
REQ-026 A d_hazard_detected stall SHALL hold head entry and all id_* outputs unchanged.

Reset
REQ-027 On rst==0 at a clk edge: count=0, head=tail=0, storage=0, counters=0; hence id_valid_inst_out=0, ifq_full=0, id_* data=0.
REQ-028 Reset SHALL override flush, push and pop; reset mid-operation discards all entries.

Configuration
REQ-029 Macro IFQ_STATS_EN SHALL, when defined, enable both counters: ifq_flush_cnt +1 per cycle with ex_branch_take==1; ifq_stall_cnt +1 per cycle with id_valid_inst_out & d_hazard_detected; both saturate at 16'hFFFF.
REQ-030 Without IFQ_STATS_EN, both counter ports SHALL be constant 0 and no counter flops SHALL exist; all other behaviour is identical.

Verification
REQ-031 Reset, then push IR=32'h00A00093 PC=0 in cycle 1 -> cycle 2 shows id_IR_out=32'h00A00093, id_PC_out=0, id_NPC_out=4, valid=1.
REQ-032 Hold d_hazard_detected=1 while pushing PC=0,4,8 -> ifq_full=1 after second push; PC=8 is not stored; head stays PC=0.
REQ-033 From FULL (PC 0,4), release hazard for one cycle -> head becomes PC=4, count=1, ifq_full=0.
REQ-034 From FULL, assert ex_branch_take together with if_valid_inst_in=1 -> next cycle id_valid_inst_out=0, ifq_full=0, id_IR_out=0.
REQ-035 Stream PC 0..28 with no stalls -> outputs PC 0..28 in order, one per cycle, count stays 1 (pointer wrap check).
REQ-036 With IFQ_STATS_EN: 3 flush cycles plus 5 valid-stall cycles -> ifq_flush_cnt=3, ifq_stall_cnt=5; then drive rst=0 for one edge -> both read 0.
